// File: rtl/cvt_int2fp_pipe_pkg.sv
// Shared IEEE-754 conversion definitions: rounding-attribute encodings and format width helpers.
package cvt_int2fp_pipe_pkg;

    localparam int LAST_RA = 1;

    typedef enum logic [LAST_RA:0] {
        RA_RNE = 2'd0,
        RA_RTZ = 2'd1,
        RA_RTP = 2'd2,
        RA_RTN = 2'd3
    } ra_e;

    function automatic int bias(input int nexp);
        return (1 << (nexp - 1)) - 1;
    endfunction

    function automatic int fmt_w(input int nexp, input int nsig);
        return nexp + nsig + 1;
    endfunction

    function automatic int lzc_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Wide enough for the unrounded biased exponent of any integer width.
    function automatic int exp_calc_w(input int intn, input int nexp);
        return ((nexp + 1) > ($clog2(intn) + 1)) ? (nexp + 1) : ($clog2(intn) + 1);
    endfunction

endpackage

// File: rtl/cvt_lzc.sv
// Combinational leading-zero counter using a binary search over a power-of-two padded word.
module cvt_lzc
    import cvt_int2fp_pipe_pkg::*;
#(
    parameter int W   = 32,
    parameter int LZW = lzc_w(W)
) (
    input  logic [W-1:0]   data_i,
    output logic [LZW-1:0] lz_o
);

    localparam int P = 1 << LZW;

    // Pad with ones below the operand so the search never runs past bit 0.
    always_comb begin
        logic [P-1:0] x;
        int           cnt;
        x   = (P'(data_i) << (P - W)) | ((P'(1'b1) << (P - W)) - P'(1'b1));
        cnt = 0;
        for (int k = LZW - 1; k >= 0; k--) begin
            if ((x >> (P - (1 << k))) == '0) begin
                cnt = cnt + (1 << k);
                x   = x << (1 << k);
            end else begin
                x   = x;
            end
        end
        lz_o = LZW'(cnt);
    end

endmodule

// File: rtl/cvt_int2fp_pipe.sv
// Three-stage integer to IEEE-754 converter: negate/latch, normalise, round/pack, with sticky flags.
module cvt_int2fp_pipe
    import cvt_int2fp_pipe_pkg::*;
#(
    parameter int INTn = 32,
    parameter int NEXP = 8,
    parameter int NSIG = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INTn-1:0]      in_data,
    input  logic                 in_signed,
    input  logic [LAST_RA:0]     in_ra,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   out_data,
    output logic                 out_inexact,
    output logic                 out_overflow,
    input  logic                 clr_flags,
    output logic                 flag_inexact,
    output logic                 flag_overflow
);

    localparam int FW    = fmt_w(NEXP, NSIG);
    localparam int MW    = NSIG + 1;
    localparam int EW    = exp_calc_w(INTn, NEXP);
    localparam int LZW   = lzc_w(INTn);
    localparam int EBASE = INTn - 1 + bias(NEXP);
    localparam logic [EW:0] EMAX = (EW+1)'((1 << NEXP) - 1);

    logic en1_s, en2_s, en3_s;
    logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
    logic sign_s, sign1_q, sign2_q;
    logic [INTn-1:0] mag_s, mag1_q, norm_s, norm2_q;
    ra_e ra1_q, ra2_q;
    logic [LZW-1:0] lz_s;
    logic [EW-1:0] exp_s, exp2_q;
    logic [MW-1:0] keep_s;
    logic guard_s, sticky_s, inexact_s, rne_inc_s, inc_s, inf_sel_s, ovf_s, zero_s;
    logic [NSIG:0] frac_sum_s;
    logic [EW:0] exp_r_s, exp_n_s;
    logic [FW-1:0] res_s, data3_q;
    logic inx3_q, ovf3_q, fi_q, fo_q, fi_d, fo_d;

    assign en3_s    = ~v3_q | out_ready;
    assign en2_s    = ~v2_q | en3_s;
    assign en1_s    = ~v1_q | en2_s;
    assign v1_d     = en1_s ? in_valid : v1_q;
    assign v2_d     = en2_s ? v1_q : v2_q;
    assign v3_d     = en3_s ? v2_q : v3_q;
    assign in_ready = en1_s;

    // The most negative signed operand negates to itself, which is its exact magnitude.
    always_comb begin
        sign_s = in_signed & in_data[INTn-1];
        if (sign_s) begin
            mag_s = ~in_data + {{(INTn-1){1'b0}}, 1'b1};
        end else begin
            mag_s = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            mag1_q  <= '0;
            ra1_q   <= RA_RNE;
        end else begin
            v1_q <= v1_d;
            if (en1_s) begin
                sign1_q <= sign_s;
                mag1_q  <= mag_s;
                ra1_q   <= ra_e'(in_ra);
            end
        end
    end

    cvt_lzc #(.W(INTn)) u_lzc (
        .data_i (mag1_q),
        .lz_o   (lz_s)
    );

    assign norm_s = mag1_q << lz_s;
    assign exp_s  = EW'(EBASE) - {{(EW-LZW){1'b0}}, lz_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            norm2_q <= '0;
            exp2_q  <= '0;
            ra2_q   <= RA_RNE;
        end else begin
            v2_q <= v2_d;
            if (en2_s) begin
                sign2_q <= sign1_q;
                norm2_q <= norm_s;
                exp2_q  <= exp_s;
                ra2_q   <= ra1_q;
            end
        end
    end

    generate
        if (MW >= INTn) begin : g_wide
            assign keep_s   = MW'(norm2_q) << (MW - INTn);
            assign guard_s  = 1'b0;
            assign sticky_s = 1'b0;
        end else begin : g_narrow
            logic [INTn-1:0] rest_s;
            assign keep_s   = norm2_q[INTn-1 -: MW];
            assign rest_s   = norm2_q << MW;
            assign guard_s  = rest_s[INTn-1];
            assign sticky_s = |rest_s[INTn-2:0];
        end
    endgenerate

    // A normalised nonzero magnitude always carries its leading one.
    assign zero_s     = ~keep_s[MW-1];
    assign inexact_s  = guard_s | sticky_s;
    assign rne_inc_s  = guard_s & (sticky_s | keep_s[0]);
    assign frac_sum_s = {1'b0, keep_s[NSIG-1:0]} + {{NSIG{1'b0}}, inc_s};
    assign exp_r_s    = {1'b0, exp2_q} + {{EW{1'b0}}, frac_sum_s[NSIG]};
    assign exp_n_s    = {1'b0, exp2_q} + {{EW{1'b0}}, rne_inc_s & (&keep_s[NSIG-1:0])};
    // A magnitude at or past the nearest-rounding threshold above max finite flags overflow in every mode.
    assign ovf_s      = ~zero_s & ((exp_r_s >= EMAX) | (exp_n_s >= EMAX));

    always_comb begin
        case (ra2_q)
            RA_RNE:  begin inc_s = rne_inc_s;             inf_sel_s = 1'b1;     end
            RA_RTZ:  begin inc_s = 1'b0;                  inf_sel_s = 1'b0;     end
            RA_RTP:  begin inc_s = ~sign2_q & inexact_s;  inf_sel_s = ~sign2_q; end
            RA_RTN:  begin inc_s = sign2_q & inexact_s;   inf_sel_s = sign2_q;  end
            default: begin inc_s = 1'b0;                  inf_sel_s = 1'b0;     end
        endcase
    end

    always_comb begin
        if (zero_s) begin
            res_s = '0;
        end else if (ovf_s && inf_sel_s) begin
            res_s = {sign2_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (ovf_s) begin
            res_s = {sign2_q, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
        end else begin
            res_s = {sign2_q, exp_r_s[NEXP-1:0], frac_sum_s[NSIG-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q    <= 1'b0;
            data3_q <= '0;
            inx3_q  <= 1'b0;
            ovf3_q  <= 1'b0;
        end else begin
            v3_q <= v3_d;
            if (en3_s) begin
                data3_q <= res_s;
                inx3_q  <= ~zero_s & (inexact_s | ovf_s);
                ovf3_q  <= ovf_s;
            end
        end
    end

    // A flag raised by this cycle's handshake survives a simultaneous clear.
    always_comb begin
        if (clr_flags) begin
            fi_d = v3_q & out_ready & inx3_q;
            fo_d = v3_q & out_ready & ovf3_q;
        end else begin
            fi_d = fi_q | (v3_q & out_ready & inx3_q);
            fo_d = fo_q | (v3_q & out_ready & ovf3_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fi_q <= 1'b0;
            fo_q <= 1'b0;
        end else begin
            fi_q <= fi_d;
            fo_q <= fo_d;
        end
    end

    assign out_valid     = v3_q;
    assign out_data      = data3_q;
    assign out_inexact   = inx3_q;
    assign out_overflow  = ovf3_q;
    assign flag_inexact  = fi_q;
    assign flag_overflow = fo_q;

endmodule
